rf_dump_unit: RTL and testbench

//   Debug reader that sweeps the register file through one read port and streams each

---
 rtl/rf_dump_unit.sv | 144 ++++++++++++++
 tb/tb_rf_dump_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_dump_unit.sv
// rf_dump_unit: debug reader that sweeps the register file through one read
// port and streams each register value out over a valid/ready interface.
// Optional feature macro: RF_DUMP_CHECKSUM_EN adds a trailing checksum beat
// carrying the modulo-2**D_WIDTH sum of every emitted register word.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; outputs quiet
// READ  | rd_addr is on the read port; capture rd_data into the beat
// SEND  | beat presented; held until handshake, then advance or finish
// CSUM  | (checksum build only) present the checksum beat
// DONE  | one-cycle done pulse, busy already low
module rf_dump_unit #(
    parameter int A_WIDTH = 5,
    parameter int D_WIDTH = 32,
    parameter bit SKIP_X0 = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic [A_WIDTH-1:0] rd_addr,
    input  logic [D_WIDTH-1:0] rd_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] out_data,
    output logic [A_WIDTH-1:0] out_idx,
    output logic               out_is_csum,
    output logic               busy,
    output logic               done
);

    localparam logic [A_WIDTH-1:0] FIRST = SKIP_X0 ? A_WIDTH'(1) : '0;
    localparam logic [A_WIDTH-1:0] LAST  = '1;

`ifdef RF_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, READ, SEND, CSUM, DONE} state_t;
    logic [D_WIDTH-1:0] csum;
`else
    typedef enum logic [2:0] {IDLE, READ, SEND, DONE} state_t;
    assign out_is_csum = 1'b0;
`endif

    state_t state;

    // Sweep sequencer; every output is a register so the sink sees clean beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef RF_DUMP_CHECKSUM_EN
            out_is_csum <= 1'b0;
            csum        <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rd_addr <= FIRST;
                        busy    <= 1'b1;
                        state   <= READ;
`ifdef RF_DUMP_CHECKSUM_EN
                        csum    <= '0;
`endif
                    end
                end
                READ: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        out_data  <= rd_data;
                        out_idx   <= rd_addr;
                        out_valid <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    // abort wins over a handshake landing on the same edge
                    if (abort) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
`ifdef RF_DUMP_CHECKSUM_EN
                        csum <= csum + out_data;
`endif
                        if (rd_addr == LAST) begin
`ifdef RF_DUMP_CHECKSUM_EN
                            state <= CSUM;
`else
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
`endif
                        end else begin
                            rd_addr <= rd_addr + A_WIDTH'(1);
                            state   <= READ;
                        end
                    end
                end
`ifdef RF_DUMP_CHECKSUM_EN
                CSUM: begin
                    // first cycle loads the beat, like READ; then hold until handshake
                    if (abort) begin
                        out_valid   <= 1'b0;
                        out_is_csum <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else if (!out_valid) begin
                        out_data    <= csum;
                        out_idx     <= '0;
                        out_is_csum <= 1'b1;
                        out_valid   <= 1'b1;
                    end else if (out_ready) begin
                        out_valid   <= 1'b0;
                        out_is_csum <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end
                end
`endif
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_dump_unit.sv
// Scoreboard bench for rf_dump_unit: two instances (x0 skipped / not skipped)
// read a bench-owned register array; expected beats are queued at start and
// popped by negedge monitors on every handshake.
module tb_rf_dump_unit;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  idx;
        logic        csum;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] rf [32];

    logic        start = 1'b0, abort = 1'b0, out_ready = 1'b1;
    logic [4:0]  rd_addr, out_idx;
    logic [31:0] rd_data, out_data;
    logic        out_valid, out_is_csum, busy, done;

    logic        start0 = 1'b0, abort0 = 1'b0, out_ready0 = 1'b1;
    logic [4:0]  rd_addr0, out_idx0;
    logic [31:0] rd_data0, out_data0;
    logic        out_valid0, out_is_csum0, busy0, done0;

    int    vectors = 0;
    int    miscompares = 0;
    bit    rand_ready = 1'b0;
    beat_t q1[$];
    beat_t q0[$];

    assign rd_data  = rf[rd_addr];
    assign rd_data0 = rf[rd_addr0];

    always #5 clk = ~clk;

    rf_dump_unit #(.A_WIDTH(5), .D_WIDTH(32), .SKIP_X0(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .out_is_csum(out_is_csum), .busy(busy), .done(done));

    rf_dump_unit #(.A_WIDTH(5), .D_WIDTH(32), .SKIP_X0(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .rd_addr(rd_addr0), .rd_data(rd_data0), .out_valid(out_valid0),
        .out_ready(out_ready0), .out_data(out_data0), .out_idx(out_idx0),
        .out_is_csum(out_is_csum0), .busy(busy0), .done(done0));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a sweep is the snapshot of rf from the first address
    // to the top, optionally followed by the wrapped sum of those words.
    function automatic int push_sweep(input bit from_zero);
        beat_t       b;
        logic [31:0] sum = '0;
        int          n = 0;
        for (int i = (from_zero ? 0 : 1); i < 32; i++) begin
            b.data = rf[i];
            b.idx  = 5'(i);
            b.csum = 1'b0;
            sum    = sum + rf[i];
            if (from_zero) q0.push_back(b); else q1.push_back(b);
            n++;
        end
`ifdef RF_DUMP_CHECKSUM_EN
        b.data = sum;
        b.idx  = '0;
        b.csum = 1'b1;
        if (from_zero) q0.push_back(b); else q1.push_back(b);
        n++;
`endif
        return n;
    endfunction

    // Monitors: every accepted beat must match the head of the expected queue.
    always @(negedge clk) begin : mon1
        beat_t e;
        if (rst_n && out_valid && out_ready && !abort) begin
            if (q1.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL beat_unexpected: got idx %0d data %0h, expected no beat", out_idx, out_data);
            end else begin
                e = q1.pop_front();
                chk("beat_data", out_data, e.data);
                chk("beat_idx", out_idx, e.idx);
                chk("beat_csum", out_is_csum, e.csum);
            end
        end
    end

    always @(negedge clk) begin : mon0
        beat_t e;
        if (rst_n && out_valid0 && out_ready0 && !abort0) begin
            if (q0.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL beat0_unexpected: got idx %0d data %0h, expected no beat", out_idx0, out_data0);
            end else begin
                e = q0.pop_front();
                chk("beat0_data", out_data0, e.data);
                chk("beat0_idx", out_idx0, e.idx);
                chk("beat0_csum", out_is_csum0, e.csum);
            end
        end
    end

    // Random backpressure driver for the randomized sweeps.
    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic do_sweep(input int pause_idx, input int abort_idx,
                            input bit mid_start, input bit chk_busy);
        int nb = 0, busy_cyc = 0, done_cyc = 0, cyc = 0, pause_left = 0, post_abort = 0;
        bit done_seen = 1'b0, fin = 1'b0, paused = 1'b0, aborting = 1'b0;
        @(posedge clk); #1;
        nb = push_sweep(1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!fin && cyc < 1000) begin
            start = mid_start && (cyc == 5);
            if (aborting) begin
                abort    = 1'b0;
                aborting = 1'b0;
                chk("abort_busy", busy, 0);
                chk("abort_valid", out_valid, 0);
                q1.delete();
                post_abort = 1;
            end else if (abort_idx >= 0 && post_abort == 0 && busy && rd_addr == 5'(abort_idx)) begin
                abort    = 1'b1;
                aborting = 1'b1;
            end
            if (pause_idx >= 0 && !paused && out_valid && out_idx == 5'(pause_idx)) begin
                paused     = 1'b1;
                pause_left = 5;
                out_ready  = 1'b0;
            end else if (paused && pause_left == 0) begin
                out_ready = 1'b1;
            end
            @(negedge clk);
            if (busy) busy_cyc++;
            if (done) done_cyc++;
            if (pause_left > 0) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, rf[pause_idx]);
                chk("hold_idx", out_idx, pause_idx);
                pause_left--;
            end
            if (done) done_seen = 1'b1;
            else if (done_seen) fin = 1'b1;
            if (post_abort > 0) begin
                post_abort++;
                if (post_abort > 6) fin = 1'b1;
            end
            cyc++;
            @(posedge clk); #1;
        end
        chk("sweep_finished", fin, 1);
        chk("done_pulses", done_cyc, (abort_idx >= 0) ? 0 : 1);
        if (chk_busy) chk("busy_cycles", busy_cyc, 2 * nb);
        chk("queue_drained", q1.size(), 0);
        start = 1'b0;
        abort = 1'b0;
        if (!rand_ready) out_ready = 1'b1;
    endtask

    task automatic do_sweep0();
        int cyc = 0;
        bit seen = 1'b0;
        @(posedge clk); #1;
        void'(push_sweep(1'b1));
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        while (!seen && cyc < 1000) begin
            @(negedge clk);
            if (done0) seen = 1'b1;
            cyc++;
        end
        chk("sweep0_done", seen, 1);
        chk("queue0_drained", q0.size(), 0);
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 32; i++) rf[i] = 32'(32'h11 * i);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", rd_addr, 0);
        chk("rst_csum", out_is_csum, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // asynchronous reset in the middle of the idx-7 beat
        void'(push_sweep(1'b0));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!(out_valid && out_idx == 5'd7) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("reach_idx7", out_valid && out_idx == 5'd7, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_addr", rd_addr, 0);
        chk("arst_csum", out_is_csum, 0);
        q1.delete();
        #3;
        rst_n = 1'b1;

        do_sweep(-1, -1, 1'b0, 1'b1);   // full sweep, exact busy length
        do_sweep(3, -1, 1'b0, 1'b0);    // backpressure hold at idx 3
        do_sweep(-1, 10, 1'b1, 1'b0);   // ignored mid start, abort at idx 10
        do_sweep(-1, -1, 1'b0, 1'b1);   // restarts cleanly from idx 1
        do_sweep0();                    // sweep including x0

        rand_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            do_sweep(-1, -1, 1'b0, 1'b0);
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        do_sweep0();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
